instr_fetch_unit: RTL and testbench

Fetch stage directly upstream of the main instruction decoder in the single-cycle CPU.
- Holds the program counter and issues word reads to instruction memory over a req/ack handshake that tolerates variable latency.
- Presents the fetched instruction, its opcode field and its PC to the decoder/datapath with a valid/ready handshake.
- Computes the next PC (sequential or taken-beq target) when the consumer accepts the instruction.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/pc_next_calc.sv | 26 ++
 rtl/instr_fetch_unit.sv | 95 +++++++++
 tb/tb_instr_fetch_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding, PC step and opcode constants
// used by both the fetch unit and the instruction decoder.
package cpu_pkg;

    // Fetch FSM encoding (kept as plain constants for legacy tools)
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_VALID = 2'd2;

    localparam int unsigned PC_INC = 4;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Opcode field of a 32-bit instruction word
    function automatic logic [5:0] opcode_of(input logic [31:0] instr);
        return instr[31:26];
    endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC adder: sequential PC+4, or PC+4 plus the word-scaled signed
// beq offset when the branch is taken. Wraps modulo 2^ADDR_W.
module pc_next_calc
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              branch_taken_i,
    input  logic [15:0]       branch_off_i,
    output logic [ADDR_W-1:0] next_pc_o
);

    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] off_ext;
    logic [ADDR_W-1:0] br_ofs;

    // Sign-extend the 16-bit immediate, scale to bytes, select target
    always_comb begin
        pc_plus4  = pc_i + ADDR_W'(PC_INC);
        off_ext   = {{(ADDR_W-16){branch_off_i[15]}}, branch_off_i};
        br_ofs    = off_ext << 2;
        next_pc_o = branch_taken_i ? (pc_plus4 + br_ofs) : pc_plus4;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: holds the PC, reads instruction memory over a
// req/ack handshake and hands the word to the decoder via valid/ready.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | one bubble after reset release, outputs quiet
// ST_REQ   | request pending at pc_q, waiting for imem_ack_i
// ST_VALID | instr_q holds a fetched word, waiting for instr_ready_i
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int              ADDR_W   = 32,
    parameter int              DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [DATA_W-1:0] imem_data_i,
    output logic              instr_valid_o,
    input  logic              instr_ready_i,
    output logic [DATA_W-1:0] instr_o,
    output logic [5:0]        op_o,
    output logic [ADDR_W-1:0] pc_o,
    input  logic              branch_taken_i,
    input  logic [15:0]       branch_off_i
);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] next_pc;

    pc_next_calc #(
        .ADDR_W (ADDR_W)
    ) u_pc_next_calc (
        .pc_i           (pc_q),
        .branch_taken_i (branch_taken_i),
        .branch_off_i   (branch_off_i),
        .next_pc_o      (next_pc)
    );

    // Next-state logic; ack is only honoured in REQ, branch inputs only on accept
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (imem_ack_i) begin
                    instr_d = imem_data_i;
                    state_d = ST_VALID;
                end
            end
            ST_VALID: begin
                if (instr_ready_i) begin
                    pc_d    = next_pc;
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, PC and instruction registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // Outputs decode straight from registers so reset silences them at once
    always_comb begin
        imem_req_o    = (state_q == ST_REQ);
        imem_addr_o   = pc_q;
        instr_valid_o = (state_q == ST_VALID);
        instr_o       = instr_q;
        op_o          = opcode_of(instr_q[31:0]);
        pc_o          = pc_q;
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
    import cpu_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [5:0]  op_o;
    logic [31:0] pc_o;
    logic        branch_taken_i;
    logic [15:0] branch_off_i;

    instr_fetch_unit #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .RESET_PC (32'h0)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_ack_i     (imem_ack_i),
        .imem_data_i    (imem_data_i),
        .instr_valid_o  (instr_valid_o),
        .instr_ready_i  (instr_ready_i),
        .instr_o        (instr_o),
        .op_o           (op_o),
        .pc_o           (pc_o),
        .branch_taken_i (branch_taken_i),
        .branch_off_i   (branch_off_i)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;

    // scoreboard entries: {pc, instruction}
    logic [63:0] sb[$];
    logic [31:0] exp_pc;
    int          cyc;
    int          req_idx, acc_idx;
    int          req_cycles, cur_wait, stall_left;
    bit          req_seen, acked_prev, fresh;
    int          acc_cyc[3];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [5:0] op;
        case (a[4:2])
            3'd0:    op = OP_RTYPE;
            3'd1:    op = OP_ADDI;
            3'd2:    op = OP_SLTI;
            3'd3:    op = OP_BEQ;
            3'd4:    op = OP_LW;
            3'd5:    op = OP_SW;
            3'd6:    op = 6'h3F;
            default: op = 6'h15;
        endcase
        return {op, a[27:2] ^ 26'h2A5A5A5};
    endfunction

    // memory wait cycles per request index
    function automatic int wait_for(input int idx);
        case (idx)
            4:       return 3;
            17:      return 10;
            default: return 0;
        endcase
    endfunction

    // consumer stall cycles per instruction index
    function automatic int stall_for(input int idx);
        return (idx == 5) ? 5 : 0;
    endfunction

    // branch decision per accepted instruction: {taken, offset}
    function automatic logic [16:0] plan_for(input int idx);
        case (idx)
            8:       return {1'b1, 16'h0003}; // 0x20 -> 0x30
            9:       return {1'b1, 16'hFFFB}; // 0x30 -> 0x20
            11:      return {1'b1, 16'hFFF8}; // 0x24 -> 0x08
            12:      return {1'b1, 16'hFFFD}; // 0x08 -> 0x00
            13:      return {1'b1, 16'hFFFF}; // 0x00 -> 0x00 (self loop)
            14:      return {1'b1, 16'hFFFE}; // 0x00 -> 0xFFFFFFFC
            default: return {1'b0, 16'h1234}; // offset must be ignored
        endcase
    endfunction

    task automatic step();
        logic [16:0] pl;
        logic [63:0] e;
        @(negedge clk_i);
        cyc++;
        if (acked_prev) chk("valid_after_ack", instr_valid_o, 1);
        acked_prev = 0;
        // memory model
        if (imem_req_o) begin
            if (!req_seen) begin
                req_seen   = 1;
                req_cycles = 0;
                cur_wait   = wait_for(req_idx);
                req_idx++;
            end
            req_cycles++;
            chk("imem_addr", imem_addr_o, exp_pc);
            if (req_cycles > cur_wait) begin
                imem_ack_i  = 1;
                imem_data_i = word_at(exp_pc);
                sb.push_back({exp_pc, word_at(exp_pc)});
                req_seen   = 0;
                acked_prev = 1;
                fresh      = 1;
            end else begin
                imem_ack_i  = 0;
                imem_data_i = $urandom;
            end
        end else begin
            chk("req_dropped_early", req_seen, 0);
            req_seen    = 0;
            imem_ack_i  = 1;              // stray ack, must be ignored
            imem_data_i = 32'hDEAD_BEEF;
        end
        // consumer model
        if (instr_valid_o) begin
            chk("req_during_valid", imem_req_o, 0);
            if (sb.size() == 0) begin
                chk("valid_without_fetch", instr_valid_o, 0);
                instr_ready_i = 1;
            end else begin
                e = sb[0];
                chk("instr_o", instr_o, e[31:0]);
                chk("pc_o", pc_o, e[63:32]);
                chk("op_o", op_o, e[31:26]);
                if (fresh) begin
                    stall_left = stall_for(acc_idx);
                    fresh = 0;
                end
                if (stall_left > 0) begin
                    stall_left--;
                    instr_ready_i  = 0;
                    branch_taken_i = 1;
                    branch_off_i   = 16'($urandom);
                end else begin
                    pl = plan_for(acc_idx);
                    instr_ready_i  = 1;
                    branch_taken_i = pl[16];
                    branch_off_i   = pl[15:0];
                    if (acc_idx < 3) acc_cyc[acc_idx] = cyc;
                    acc_idx++;
                    void'(sb.pop_front());
                    exp_pc = exp_pc + 32'd4 +
                             (pl[16] ? ({{16{pl[15]}}, pl[15:0]} << 2) : 32'd0);
                end
            end
        end else begin
            instr_ready_i  = 1'($urandom_range(0, 1));
            branch_taken_i = 1'($urandom_range(0, 1));
            branch_off_i   = 16'($urandom);
        end
    endtask

    initial begin
        rst_i = 0; imem_ack_i = 0; imem_data_i = '0;
        instr_ready_i = 0; branch_taken_i = 0; branch_off_i = '0;
        exp_pc = 32'h0; cyc = 0; req_idx = 0; acc_idx = 0;
        req_cycles = 0; cur_wait = 0; stall_left = 0;
        req_seen = 0; acked_prev = 0; fresh = 0;
        #3;
        chk("rst_req", imem_req_o, 0);
        chk("rst_valid", instr_valid_o, 0);
        chk("rst_op", op_o, 0);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_instr", instr_o, 0);
        repeat (2) @(negedge clk_i);
        rst_i = 1;
        #1 chk("idle_bubble", imem_req_o, 0);
        @(posedge clk_i);
        #1 chk("req_rise", imem_req_o, 1);

        while (acc_idx < 17 && cyc < 2000) step();
        chk("progress_main", acc_idx, 17);
        chk("tput_0_1", acc_cyc[1] - acc_cyc[0], 2);
        chk("tput_1_2", acc_cyc[2] - acc_cyc[1], 2);

        // reset while request 17 is waiting on memory
        while (!(req_idx == 18 && req_seen && req_cycles >= 2) && cyc < 2000) step();
        chk("reached_pending_req", req_idx, 18);
        #2 rst_i = 0;
        #1;
        chk("midrst_req", imem_req_o, 0);
        chk("midrst_valid", instr_valid_o, 0);
        chk("midrst_pc", pc_o, 32'h0);
        chk("midrst_op", op_o, 0);
        exp_pc = 32'h0; sb.delete();
        req_seen = 0; acked_prev = 0; fresh = 0; stall_left = 0;
        @(negedge clk_i);
        rst_i = 1;
        imem_ack_i = 1; imem_data_i = 32'hBAD0_0BAD; instr_ready_i = 1;
        #1 chk("post_rst_idle", imem_req_o, 0);
        while (acc_idx < 20 && cyc < 2000) step();
        chk("progress_post_rst", acc_idx, 20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
